// File: rtl/frontend_arbiter.sv
// Two-requester round-robin arbiter in front of the ORAM Frontend.
// A grant covers one command plus its full data burst (Chunks beats).
// Write data and read-return data are steered combinationally between the
// owner and the Frontend; nothing is buffered on the data path.
module frontend_arbiter #(
    parameter int ORAMU      = 32,
    parameter int ORAMB      = 512,
    parameter int FEDWidth   = 64,
    parameter int BECMDWidth = 2,
    parameter int DMWidth    = 64
) (
    input  logic                  Clock,
    input  logic                  Reset,

    input  logic                  CmdInValid_0,
    output logic                  CmdInReady_0,
    input  logic [BECMDWidth-1:0] CmdIn_0,
    input  logic [ORAMU-1:0]      ProgAddrIn_0,
    input  logic [DMWidth-1:0]    WMaskIn_0,
    input  logic                  DataInValid_0,
    output logic                  DataInReady_0,
    input  logic [FEDWidth-1:0]   DataIn_0,
    output logic                  ReturnDataValid_0,
    input  logic                  ReturnDataReady_0,
    output logic [FEDWidth-1:0]   ReturnData_0,

    input  logic                  CmdInValid_1,
    output logic                  CmdInReady_1,
    input  logic [BECMDWidth-1:0] CmdIn_1,
    input  logic [ORAMU-1:0]      ProgAddrIn_1,
    input  logic [DMWidth-1:0]    WMaskIn_1,
    input  logic                  DataInValid_1,
    output logic                  DataInReady_1,
    input  logic [FEDWidth-1:0]   DataIn_1,
    output logic                  ReturnDataValid_1,
    input  logic                  ReturnDataReady_1,
    output logic [FEDWidth-1:0]   ReturnData_1,

    output logic                  FeCmdValid,
    input  logic                  FeCmdReady,
    output logic [BECMDWidth-1:0] FeCmd,
    output logic [ORAMU-1:0]      FeAddr,
    output logic [DMWidth-1:0]    FeWMask,

    output logic                  FeDataValid,
    input  logic                  FeDataReady,
    output logic [FEDWidth-1:0]   FeData,

    input  logic                  FeReturnValid,
    output logic                  FeReturnReady,
    input  logic [FEDWidth-1:0]   FeReturn,

    output logic                  Owner,
    output logic                  Busy
);

    localparam int CHUNKS = ORAMB / FEDWidth;
    localparam int BEAT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(CHUNKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WDATA,
        ST_RDATA
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic                    r_owner;
    logic                    r_last_grant;
    logic [BEAT_W-1:0]       r_beat;
    logic [BECMDWidth-1:0]   r_cmd;
    logic [ORAMU-1:0]        r_addr;
    logic [DMWidth-1:0]      r_mask;

    logic                    w_any_valid;
    logic                    w_winner;
    logic                    w_accept;
    logic                    w_din_valid;
    logic [FEDWidth-1:0]     w_din_data;
    logic                    w_ret_ready;
    logic                    w_beat_fire;
    logic                    w_last_beat;
    logic                    w_cmd_fire;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        w_any_valid = CmdInValid_0 | CmdInValid_1;
        if (CmdInValid_0 && CmdInValid_1) begin
            w_winner = ~r_last_grant;
        end else begin
            w_winner = CmdInValid_1;
        end
        w_accept = Reset && (r_state == ST_IDLE) && w_any_valid;
    end

    // Owner-side data selection and beat handshake detection.
    always_comb begin
        w_din_valid = r_owner ? DataInValid_1 : DataInValid_0;
        w_din_data  = r_owner ? DataIn_1 : DataIn_0;
        w_ret_ready = r_owner ? ReturnDataReady_1 : ReturnDataReady_0;
        w_cmd_fire  = (r_state == ST_ISSUE) && FeCmdReady;
        w_beat_fire = ((r_state == ST_WDATA) && w_din_valid && FeDataReady) ||
                      ((r_state == ST_RDATA) && FeReturnValid && w_ret_ready);
        w_last_beat = w_beat_fire && (r_beat == BEAT_LAST);
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: one command, then its full burst, then back to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (FeCmdReady) begin
                    w_next_state = r_cmd[1] ? ST_RDATA : ST_WDATA;
                end
            end
            ST_WDATA, ST_RDATA: begin
                if (w_last_beat) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Command latch, grant history and beat counter.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_beat       <= '0;
            r_cmd        <= '0;
            r_addr       <= '0;
            r_mask       <= '0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                r_cmd        <= w_winner ? CmdIn_1 : CmdIn_0;
                r_addr       <= w_winner ? ProgAddrIn_1 : ProgAddrIn_0;
                r_mask       <= w_winner ? WMaskIn_1 : WMaskIn_0;
            end
            if (w_cmd_fire) begin
                r_beat <= '0;
            end else if (w_beat_fire) begin
                r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
            end
        end
    end

    assign FeCmd   = r_cmd;
    assign FeAddr  = r_addr;
    assign FeWMask = r_mask;

    // FSM outputs; every handshake output is forced low while Reset is asserted.
    always_comb begin
        CmdInReady_0      = 1'b0;
        CmdInReady_1      = 1'b0;
        DataInReady_0     = 1'b0;
        DataInReady_1     = 1'b0;
        ReturnDataValid_0 = 1'b0;
        ReturnDataValid_1 = 1'b0;
        ReturnData_0      = FeReturn;
        ReturnData_1      = FeReturn;
        FeCmdValid        = 1'b0;
        FeDataValid       = 1'b0;
        FeData            = w_din_data;
        FeReturnReady     = 1'b0;
        Busy              = Reset && (r_state != ST_IDLE);
        Owner             = Reset && r_owner;
        if (Reset) begin
            case (r_state)
                ST_IDLE: begin
                    CmdInReady_0 = w_any_valid && !w_winner;
                    CmdInReady_1 = w_any_valid && w_winner;
                end
                ST_ISSUE: begin
                    FeCmdValid = 1'b1;
                end
                ST_WDATA: begin
                    FeDataValid = w_din_valid;
                    if (r_owner) begin
                        DataInReady_1 = FeDataReady;
                    end else begin
                        DataInReady_0 = FeDataReady;
                    end
                end
                ST_RDATA: begin
                    FeReturnReady = w_ret_ready;
                    if (r_owner) begin
                        ReturnDataValid_1 = FeReturnValid;
                    end else begin
                        ReturnDataValid_0 = FeReturnValid;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frontend_arbiter.sv
// Directed bench for frontend_arbiter with scoreboard queues: stimulus pushes
// expected grants, commands and data beats; a negedge monitor pops and compares
// whenever the DUT completes a handshake.
module tb_frontend_arbiter;

    logic        Clock;
    logic        Reset;
    logic        cv0, cv1;
    logic        crdy0, crdy1;
    logic [1:0]  cmd0, cmd1;
    logic [31:0] addr0, addr1;
    logic [63:0] mask0, mask1;
    logic        dv0, dv1, drdy0, drdy1;
    logic [63:0] d0, d1;
    logic        rv0, rv1, rr0, rr1;
    logic [63:0] rd0, rd1;
    logic        FeCmdValid, fe_cmd_ready;
    logic [1:0]  FeCmd;
    logic [31:0] FeAddr;
    logic [63:0] FeWMask;
    logic        FeDataValid, fe_data_ready;
    logic [63:0] FeData;
    logic        fe_ret_valid, FeReturnReady;
    logic [63:0] fe_ret;
    logic        Owner, Busy;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    int          q_grant[$];
    logic [97:0] q_cmd[$];
    logic [63:0] q_wdata[$];
    logic [63:0] q_rd0[$];
    logic [63:0] q_rd1[$];

    frontend_arbiter #(
        .ORAMU(32), .ORAMB(512), .FEDWidth(64), .BECMDWidth(2), .DMWidth(64)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .CmdInValid_0(cv0), .CmdInReady_0(crdy0), .CmdIn_0(cmd0),
        .ProgAddrIn_0(addr0), .WMaskIn_0(mask0),
        .DataInValid_0(dv0), .DataInReady_0(drdy0), .DataIn_0(d0),
        .ReturnDataValid_0(rv0), .ReturnDataReady_0(rr0), .ReturnData_0(rd0),
        .CmdInValid_1(cv1), .CmdInReady_1(crdy1), .CmdIn_1(cmd1),
        .ProgAddrIn_1(addr1), .WMaskIn_1(mask1),
        .DataInValid_1(dv1), .DataInReady_1(drdy1), .DataIn_1(d1),
        .ReturnDataValid_1(rv1), .ReturnDataReady_1(rr1), .ReturnData_1(rd1),
        .FeCmdValid(FeCmdValid), .FeCmdReady(fe_cmd_ready), .FeCmd(FeCmd),
        .FeAddr(FeAddr), .FeWMask(FeWMask),
        .FeDataValid(FeDataValid), .FeDataReady(fe_data_ready), .FeData(FeData),
        .FeReturnValid(fe_ret_valid), .FeReturnReady(FeReturnReady), .FeReturn(fe_ret),
        .Owner(Owner), .Busy(Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every completed handshake must match the head of its queue.
    always @(negedge Clock) begin
        if (cv0 && crdy0) begin
            chk("grant_expected", q_grant.size() != 0, 1);
            if (q_grant.size() != 0) chk("grant_order", 0, q_grant.pop_front());
        end
        if (cv1 && crdy1) begin
            chk("grant_expected", q_grant.size() != 0, 1);
            if (q_grant.size() != 0) chk("grant_order", 1, q_grant.pop_front());
        end
        if (FeCmdValid && fe_cmd_ready) begin
            chk("cmd_expected", q_cmd.size() != 0, 1);
            if (q_cmd.size() != 0) chk("fe_cmd_fields", {FeCmd, FeAddr, FeWMask}, q_cmd.pop_front());
        end
        if (FeDataValid && fe_data_ready) begin
            chk("wdata_expected", q_wdata.size() != 0, 1);
            if (q_wdata.size() != 0) chk("fe_data", FeData, q_wdata.pop_front());
        end
        if (rv0 && rr0) begin
            chk("rdata0_expected", q_rd0.size() != 0, 1);
            if (q_rd0.size() != 0) chk("return_data_0", rd0, q_rd0.pop_front());
        end
        if (rv1 && rr1) begin
            chk("rdata1_expected", q_rd1.size() != 0, 1);
            if (q_rd1.size() != 0) chk("return_data_1", rd1, q_rd1.pop_front());
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_cmd(input int who, input logic [1:0] c, input logic [31:0] a,
                              input logic [63:0] m);
        q_grant.push_back(who);
        q_cmd.push_back({c, a, m});
    endtask

    // Wait (bounded) for requester x to be accepted; then drop or re-issue.
    task automatic wait_accept(input int x, input bit keep, output bit ok);
        bit hs;
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clock);
            hs = (x == 0) ? (cv0 && crdy0) : (cv1 && crdy1);
            tick();
            if (hs) begin
                ok = 1'b1;
                if (x == 0) begin
                    if (keep) addr0 = addr0 + 32'h10; else cv0 = 1'b0;
                end else begin
                    if (keep) addr1 = addr1 + 32'h10; else cv1 = 1'b0;
                end
                break;
            end
        end
        chk("accept_in_time", ok, 1'b1);
    endtask

    // The single ISSUE cycle that follows an accept when FeCmdReady is high.
    task automatic issue_cycle(input logic [31:0] exp_addr);
        @(negedge Clock);
        chk("fe_cmd_valid", FeCmdValid, 1'b1);
        chk("fe_addr", FeAddr, exp_addr);
        tick();
    endtask

    // Frontend return source: presents 8 beats, advancing on each accepted beat.
    task automatic feed_read(input int owner, input bit toggle, input logic [63:0] base);
        int   idx;
        logic rr_exp;
        logic hs;
        for (int i = 0; i < 8; i++) begin
            if (owner == 0) q_rd0.push_back(base + 64'(i));
            else q_rd1.push_back(base + 64'(i));
        end
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            fe_ret_valid = 1'b1;
            fe_ret = base + 64'(idx);
            rr_exp = toggle ? c[0] : 1'b1;
            if (owner == 0) rr0 = rr_exp; else rr1 = rr_exp;
            @(negedge Clock);
            chk("fe_return_ready", FeReturnReady, rr_exp);
            chk("owner_rd", Owner, owner[0]);
            hs = FeReturnReady;
            tick();
            if (hs) idx++;
        end
        fe_ret_valid = 1'b0;
        rr0 = 1'b1;
        rr1 = 1'b1;
        chk("rd_beat_count", idx, 8);
        chk("rd_end_busy", Busy, 1'b0);
    endtask

    // Requester write source: 8 beats, or stops before beat abort_at.
    task automatic feed_write(input int owner, input int abort_at, input logic [63:0] base);
        int   idx;
        logic hs;
        for (int i = 0; i < 8; i++) q_wdata.push_back(base + 64'(i));
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            if (idx == abort_at) break;
            if (owner == 0) begin dv0 = 1'b1; d0 = base + 64'(idx); end
            else begin dv1 = 1'b1; d1 = base + 64'(idx); end
            @(negedge Clock);
            hs = (owner == 0) ? drdy0 : drdy1;
            chk("din_ready_owner", hs, 1'b1);
            chk("din_ready_other", (owner == 0) ? drdy1 : drdy0, 1'b0);
            chk("owner_wr", Owner, owner[0]);
            tick();
            if (hs) idx++;
        end
        if (abort_at < 0) begin
            if (owner == 0) dv0 = 1'b0; else dv1 = 1'b0;
            chk("wr_beat_count", idx, 8);
            chk("wr_end_busy", Busy, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int prev;
        int own;
        Reset = 1'b0;
        cv0 = 1'b1; cv1 = 1'b0;
        cmd0 = 2'b10; cmd1 = 2'b10;
        addr0 = '0; addr1 = '0; mask0 = '0; mask1 = '0;
        dv0 = 1'b0; dv1 = 1'b0; d0 = '0; d1 = '0;
        rr0 = 1'b1; rr1 = 1'b1;
        fe_cmd_ready = 1'b1; fe_data_ready = 1'b1;
        fe_ret_valid = 1'b0; fe_ret = '0;

        // Reset state, with a requester already valid.
        tick();
        tick();
        @(negedge Clock);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_owner", Owner, 1'b0);
        chk("rst_cmd_ready0", crdy0, 1'b0);
        chk("rst_fe_cmd_valid", FeCmdValid, 1'b0);
        chk("rst_fe_data_valid", FeDataValid, 1'b0);
        chk("rst_fe_return_ready", FeReturnReady, 1'b0);
        tick();

        // Test 1: simultaneous Reads, req0 first, then req1.
        Reset = 1'b1;
        cv0 = 1'b1; cmd0 = 2'b10; addr0 = 32'h1000; mask0 = '0;
        cv1 = 1'b1; cmd1 = 2'b10; addr1 = 32'h2000; mask1 = '0;
        expect_cmd(0, 2'b10, 32'h1000, '0);
        expect_cmd(1, 2'b10, 32'h2000, '0);
        wait_accept(0, 1'b0, ok);
        issue_cycle(32'h1000);
        feed_read(0, 1'b0, 64'hA000_0000_0000_0000);
        wait_accept(1, 1'b0, ok);
        issue_cycle(32'h2000);
        feed_read(1, 1'b0, 64'hB000_0000_0000_0000);

        // Test 2: req1 Update while req0 keeps DataInValid high.
        dv0 = 1'b1; d0 = 64'hDEAD_DEAD_DEAD_DEAD;
        cv1 = 1'b1; cmd1 = 2'b00; addr1 = 32'h1234; mask1 = '1;
        expect_cmd(1, 2'b00, 32'h1234, '1);
        wait_accept(1, 1'b0, ok);
        issue_cycle(32'h1234);
        feed_write(1, -1, 64'h1111_2222_3333_0000);
        dv0 = 1'b0;

        // Test 3: FeCmdReady held low in ISSUE; command fields must hold.
        fe_cmd_ready = 1'b0;
        cv0 = 1'b1; cmd0 = 2'b01; addr0 = 32'h3000; mask0 = 64'h00FF_00FF_00FF_00FF;
        expect_cmd(0, 2'b01, 32'h3000, 64'h00FF_00FF_00FF_00FF);
        wait_accept(0, 1'b0, ok);
        cv1 = 1'b1; cmd1 = 2'b10; addr1 = 32'h5000; mask1 = '0;
        expect_cmd(1, 2'b10, 32'h5000, '0);
        for (int i = 0; i < 5; i++) begin
            cmd0 = ~cmd0; addr0 = addr0 ^ 32'hFFFF; mask0 = ~mask0;
            @(negedge Clock);
            chk("hold_fe_cmd_valid", FeCmdValid, 1'b1);
            chk("hold_fe_cmd", FeCmd, 2'b01);
            chk("hold_fe_addr", FeAddr, 32'h3000);
            chk("hold_fe_wmask", FeWMask, 64'h00FF_00FF_00FF_00FF);
            chk("hold_cmd_ready1", crdy1, 1'b0);
            tick();
        end
        fe_cmd_ready = 1'b1;
        issue_cycle(32'h3000);
        feed_write(0, -1, 64'h3333_0000_0000_0000);
        wait_accept(1, 1'b0, ok);
        issue_cycle(32'h5000);
        feed_read(1, 1'b0, 64'h5555_0000_0000_0000);

        // Test 4: read burst with ReturnDataReady_0 toggling every cycle.
        cv0 = 1'b1; cmd0 = 2'b10; addr0 = 32'h7000; mask0 = '0;
        expect_cmd(0, 2'b10, 32'h7000, '0);
        wait_accept(0, 1'b0, ok);
        issue_cycle(32'h7000);
        feed_read(0, 1'b1, 64'h7777_0000_0000_0000);

        // Test 5: reset on beat 3 of a write burst owned by req0.
        cv0 = 1'b1; cmd0 = 2'b00; addr0 = 32'h9000; mask0 = '1;
        expect_cmd(0, 2'b00, 32'h9000, '1);
        wait_accept(0, 1'b0, ok);
        issue_cycle(32'h9000);
        feed_write(0, 3, 64'h9999_0000_0000_0000);
        Reset = 1'b0;
        dv0 = 1'b1; d0 = 64'h9999_0000_0000_0003;
        cv0 = 1'b1; cmd0 = 2'b01; addr0 = 32'hC000; mask0 = {16{4'h1}};
        cv1 = 1'b1; cmd1 = 2'b01; addr1 = 32'hD000; mask1 = {16{4'h2}};
        expect_cmd(0, 2'b01, 32'hC000, {16{4'h1}});
        expect_cmd(1, 2'b01, 32'hD000, {16{4'h2}});
        expect_cmd(0, 2'b01, 32'hC010, {16{4'h1}});
        expect_cmd(1, 2'b01, 32'hD010, {16{4'h2}});
        @(negedge Clock);
        chk("rst5_busy", Busy, 1'b0);
        chk("rst5_owner", Owner, 1'b0);
        chk("rst5_din_ready0", drdy0, 1'b0);
        chk("rst5_fe_data_valid", FeDataValid, 1'b0);
        chk("rst5_cmd_ready0", crdy0, 1'b0);
        chk("rst5_cmd_ready1", crdy1, 1'b0);
        tick();
        Reset = 1'b1;
        dv0 = 1'b0;
        q_wdata.delete();
        chk("post_reset_busy", Busy, 1'b0);

        // Test 6: both requesters keep issuing Append; grants alternate 0,1,0,1.
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            own = i % 2;
            wait_accept(own, i < 2, ok);
            if (i > 0) chk("b2b_period", cyc - prev, 10);
            prev = cyc;
            issue_cycle(((own == 0) ? 32'hC000 : 32'hD000) + 32'(i / 2) * 32'h10);
            feed_write(own, -1, {32'hF00D_0000, 32'(i * 256)});
        end

        tick();
        tick();
        chk("q_grant_empty", q_grant.size(), 0);
        chk("q_cmd_empty", q_cmd.size(), 0);
        chk("q_wdata_empty", q_wdata.size(), 0);
        chk("q_rd0_empty", q_rd0.size(), 0);
        chk("q_rd1_empty", q_rd1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
